// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP and the
// fetch-to-decode entry format.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer of {instr, pc}. The head is read straight from storage
// registers, so a pushed word becomes visible the cycle after the push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         head_valid_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only consumed while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o       = mem_q[rd_q];
  assign head_valid_o = (cnt_q != '0);
  assign count_o      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory
// requests, in-order response buffering and redirect flush toward decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_take, push, pop, head_valid;
  logic [XLEN-1:0] redirect_aligned;
  fetch_entry_t    head;
  logic            unused_pc_bits;

  assign unused_pc_bits   = ^redirect_pc[1:0];
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  assign credit_used    = {1'b0, out_q} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (out_q != '0);
  assign push     = rsp_take && (disc_q == '0) && !redirect_valid;
  assign pop      = head_valid && instr_ready && !redirect_valid;

  // rsp_pc_q tracks the PC of the next kept response; stale ones never advance it.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CW'(req_fire) - CW'(rsp_take);
    disc_d   = disc_q;
    if (rsp_take && (disc_q != '0)) disc_d = disc_q - CW'(1);
    if (req_fire) pc_d = pc_q + 32'd4;
    if (push)     rsp_pc_d = rsp_pc_q + 32'd4;
    if (redirect_valid) begin
      pc_d     = redirect_aligned;
      rsp_pc_d = redirect_aligned;
      disc_d   = out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_data_i  ('{instr: imem_rsp_data, pc: rsp_pc_q}),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (fifo_count)
  );

  assign instr_valid = head_valid;
  assign instr       = head_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = head_valid ? head.pc    : rsp_pc_q;

endmodule
